// File: rtl/patch_matrix_scanner_if.sv
// Pin-side and routing-side signals of the patch matrix scanner.
// The scanner drives through the master modport; its consumer takes the slave side.
interface patch_matrix_scanner_if #(
    parameter int NUM_SRC  = 6,
    parameter int NUM_SINK = 6
);
    localparam int SRC_W = $clog2(NUM_SRC + 1);

    logic [NUM_SINK-1:0]       sense;
    logic [NUM_SRC-1:0]        drive_low;
    logic [NUM_SINK*SRC_W-1:0] src;
    logic [NUM_SINK-1:0]       conflict;
    logic                      frame_done;
    logic                      changed;

    modport master (
        input  sense,
        output drive_low,
        output src,
        output conflict,
        output frame_done,
        output changed
    );

    modport slave (
        output sense,
        input  drive_low,
        input  src,
        input  conflict,
        input  frame_done,
        input  changed
    );
endinterface

// File: rtl/patch_matrix_scanner.sv
// Walks one open-drain source low at a time, samples every sink after a settle period,
// and publishes debounced per-sink source codes plus conflict flags once per frame.
module patch_matrix_scanner #(
    parameter int NUM_SRC       = 6,
    parameter int NUM_SINK      = 6,
    parameter int SETTLE_CYCLES = 16,
    parameter int STABLE_SCANS  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    patch_matrix_scanner_if.master bus
);
    localparam int SRC_W  = $clog2(NUM_SRC + 1);
    localparam int D_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STAB_W = $clog2(STABLE_SCANS + 1);

    typedef enum logic [1:0] {
        S_DRIVE,
        S_RELEASE,
        S_COMMIT
    } state_t;

    state_t                                state_q, state_d;
    logic [D_W-1:0]                        d_q, d_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic                                  run_q, run_d;
    logic [NUM_SINK-1:0]                   sync1_q, sync2_q;
    logic [NUM_SRC-1:0][NUM_SINK-1:0]      row_q, row_d;
    logic [NUM_SINK-1:0][SRC_W-1:0]        prev_q, prev_d;
    logic [NUM_SINK-1:0][STAB_W-1:0]       stab_q, stab_d;
    logic [NUM_SINK-1:0][SRC_W-1:0]        src_q, src_d;
    logic [NUM_SINK-1:0]                   conflict_q, conflict_d;
    logic                                  frame_done_q, frame_done_d;
    logic                                  changed_q, changed_d;
    logic [NUM_SRC-1:0]                    drive_low_q, drive_low_d;
    logic                                  commit_en;
    logic [SRC_W-1:0]                      cand_v;
    int                                    hits_v;

    always_comb begin
        state_d      = state_q;
        d_d          = d_q;
        cnt_d        = cnt_q;
        run_d        = 1'b1;
        row_d        = row_q;
        commit_en    = 1'b0;
        // The first edge out of reset only arms the scan, so row 0 is driven
        // for the full settle window starting at that edge.
        if (run_q) begin
            unique case (state_q)
                S_DRIVE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        row_d[d_q] = ~sync2_q;
                        state_d    = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    cnt_d = '0;
                    if (d_q == D_W'(NUM_SRC - 1)) begin
                        state_d   = S_COMMIT;
                        commit_en = 1'b1;
                    end else begin
                        d_d     = d_q + 1'b1;
                        state_d = S_DRIVE;
                    end
                end
                S_COMMIT: begin
                    state_d = S_DRIVE;
                    d_d     = '0;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_DRIVE;
                    d_d     = '0;
                    cnt_d   = '0;
                end
            endcase
        end

        drive_low_d = '0;
        if (state_d == S_DRIVE) begin
            drive_low_d[d_d] = 1'b1;
        end
    end

    // Frame evaluation is registered on the edge entering COMMIT, so the
    // published results are visible for exactly the COMMIT cycle onward.
    always_comb begin
        prev_d       = prev_q;
        stab_d       = stab_q;
        src_d        = src_q;
        conflict_d   = conflict_q;
        frame_done_d = 1'b0;
        changed_d    = 1'b0;
        cand_v       = '0;
        hits_v       = 0;
        if (commit_en) begin
            frame_done_d = 1'b1;
            for (int k = 0; k < NUM_SINK; k++) begin
                cand_v = '0;
                hits_v = 0;
                for (int i = NUM_SRC - 1; i >= 0; i--) begin
                    if (row_q[i][k]) begin
                        cand_v = SRC_W'(i + 1);
                        hits_v = hits_v + 1;
                    end
                end
                conflict_d[k] = (hits_v > 1);
                if (cand_v == prev_q[k]) begin
                    if (stab_q[k] < STAB_W'(STABLE_SCANS)) begin
                        stab_d[k] = stab_q[k] + 1'b1;
                    end
                end else begin
                    stab_d[k] = STAB_W'(1);
                    prev_d[k] = cand_v;
                end
                if ((stab_d[k] == STAB_W'(STABLE_SCANS)) && (cand_v != src_q[k])) begin
                    src_d[k]  = cand_v;
                    changed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_DRIVE;
            d_q          <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            sync1_q      <= '1;
            sync2_q      <= '1;
            row_q        <= '0;
            prev_q       <= '0;
            stab_q       <= '0;
            src_q        <= '0;
            conflict_q   <= '0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            drive_low_q  <= '0;
        end else begin
            state_q      <= state_d;
            d_q          <= d_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            sync1_q      <= bus.sense;
            sync2_q      <= sync1_q;
            row_q        <= row_d;
            prev_q       <= prev_d;
            stab_q       <= stab_d;
            src_q        <= src_d;
            conflict_q   <= conflict_d;
            frame_done_q <= frame_done_d;
            changed_q    <= changed_d;
            drive_low_q  <= drive_low_d;
        end
    end

    assign bus.drive_low  = drive_low_q;
    assign bus.src        = src_q;
    assign bus.conflict   = conflict_q;
    assign bus.frame_done = frame_done_q;
    assign bus.changed    = changed_q;
endmodule

// File: tb/tb_patch_matrix_scanner.sv
// Self-checking bench: cable/stuck-pin environment plus a frame-level routing model.
module tb_patch_matrix_scanner;
    localparam int NS = 6;
    localparam int NK = 6;
    localparam int SW = 3;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // plug[k] = set of sources cabled to sink k; stuck[k] = sink shorted low
    logic [NS-1:0] plug [NK] = '{default: '0};
    logic [NK-1:0] stuck = '0;
    logic [NK-1:0] sense_m;
    logic [2:0]    plug_s [8] = '{default: '0};
    logic [7:0]    sense_s;

    patch_matrix_scanner_if #(.NUM_SRC(NS), .NUM_SINK(NK)) bus ();
    patch_matrix_scanner #(.NUM_SRC(NS), .NUM_SINK(NK), .SETTLE_CYCLES(16), .STABLE_SCANS(3))
        dut (.clk(clk), .rst(rst), .bus(bus));

    patch_matrix_scanner_if #(.NUM_SRC(3), .NUM_SINK(8)) bus_s ();
    patch_matrix_scanner #(.NUM_SRC(3), .NUM_SINK(8), .SETTLE_CYCLES(4), .STABLE_SCANS(1))
        dut_s (.clk(clk), .rst(rst_s), .bus(bus_s));

    always_comb begin
        sense_m = '1;
        for (int k = 0; k < NK; k++)
            if (stuck[k] || ((plug[k] & bus.drive_low) != '0)) sense_m[k] = 1'b0;
    end
    assign bus.sense = sense_m;

    always_comb begin
        sense_s = '1;
        for (int k = 0; k < 8; k++)
            if ((plug_s[k] & bus_s.drive_low) != '0) sense_s[k] = 1'b0;
    end
    assign bus_s.sense = sense_s;

    // Reference: per sink, the source codes seen in the last three frames.
    int m_src [NK];
    int m_h   [NK][3];
    int m_n   [NK];
    bit m_conf[NK];

    function automatic void model_reset();
        for (int k = 0; k < NK; k++) begin
            m_src[k] = 0; m_n[k] = 0; m_conf[k] = 0;
            for (int j = 0; j < 3; j++) m_h[k][j] = 0;
        end
    endfunction

    function automatic bit model_frame();
        bit any;
        any = 0;
        for (int k = 0; k < NK; k++) begin
            logic [NS-1:0] eff;
            int cand;
            eff  = stuck[k] ? '1 : plug[k];
            cand = 0;
            for (int i = NS - 1; i >= 0; i--) if (eff[i]) cand = i + 1;
            m_conf[k] = ($countones(eff) > 1);
            m_h[k][0] = m_h[k][1];
            m_h[k][1] = m_h[k][2];
            m_h[k][2] = cand;
            if (m_n[k] < 3) m_n[k]++;
            if (m_n[k] == 3 && m_h[k][0] == cand && m_h[k][1] == cand && cand != m_src[k]) begin
                m_src[k] = cand;
                any = 1;
            end
        end
        return any;
    endfunction

    function automatic logic [NK*SW-1:0] model_src_vec();
        logic [NK*SW-1:0] v;
        v = '0;
        for (int k = 0; k < NK; k++) v[k*SW +: SW] = SW'(m_src[k]);
        return v;
    endfunction

    function automatic logic [NK-1:0] model_conf_vec();
        logic [NK-1:0] v;
        for (int k = 0; k < NK; k++) v[k] = m_conf[k];
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < NK; k++) plug[k] = '0;
        stuck = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advances to the next frame_done (bounded) and steps the model once.
    task automatic step_frame(output int cyc, output bit ok, output int stray, output bit mch);
        cyc = 0;
        stray = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (bus.changed && !bus.frame_done) stray++;
        end while (!bus.frame_done && cyc < 400);
        ok  = bus.frame_done;
        mch = model_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.drive_low !== '0 || bus.src !== '0 || bus.conflict !== '0 ||
            bus.frame_done !== 1'b0 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: drive=%b src=%h conf=%b fd=%b ch=%b, required all zero",
                     bus.drive_low, bus.src, bus.conflict, bus.frame_done, bus.changed);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.drive_low !== 6'b000001) begin
            errors++;
            $display("FAIL first_drive: got %b required 000001", bus.drive_low);
        end
    endtask

    task automatic test_idle_walk();
        logic [NS-1:0] exp;
        int cyc, stray;
        bit ok, mch;
        do_reset();
        for (int c = 0; c < 103; c++) begin
            @(posedge clk); #1;
            exp = '0;
            if (c < 102 && (c % 17) < 16) exp[c / 17] = 1'b1;
            checks++;
            if (bus.drive_low !== exp) begin
                errors++;
                $display("FAIL idle_drive c=%0d: got %b required %b", c, bus.drive_low, exp);
            end
            checks++;
            if (bus.frame_done !== (c == 102)) begin
                errors++;
                $display("FAIL idle_frame_done c=%0d: got %b required %b", c, bus.frame_done, (c == 102));
            end
        end
        void'(model_frame());
        for (int f = 0; f < 2; f++) begin
            step_frame(cyc, ok, stray, mch);
            checks++;
            if (!ok || cyc != 103 || bus.src !== '0 || bus.conflict !== '0 || bus.changed !== 1'b0 || stray != 0) begin
                errors++;
                $display("FAIL idle_frame f=%0d: cyc=%0d src=%h conf=%b ch=%b stray=%0d, required 103/0/0/0/0",
                         f, cyc, bus.src, bus.conflict, bus.changed, stray);
            end
        end
    endtask

    task automatic test_cable();
        int cyc, stray, total, nch;
        bit ok, mch;
        do_reset();
        plug[4] = 6'b000100;
        total = 0; nch = 0;
        for (int f = 1; f <= 4; f++) begin
            step_frame(cyc, ok, stray, mch);
            total += cyc;
            if (bus.changed === 1'b1) nch++;
            checks++;
            if (!ok || bus.src !== model_src_vec() || bus.changed !== mch || stray != 0) begin
                errors++;
                $display("FAIL cable f=%0d: src=%h ch=%b stray=%0d, required src=%h ch=%b stray=0",
                         f, bus.src, bus.changed, stray, model_src_vec(), mch);
            end
            if (f == 3) begin
                checks++;
                if (total != 309 || bus.src !== 18'(3 << 12)) begin
                    errors++;
                    $display("FAIL cable_commit: cycle=%0d src=%h, required cycle=309 src=%h",
                             total, bus.src, 18'(3 << 12));
                end
            end
        end
        checks++;
        if (nch != 1) begin
            errors++;
            $display("FAIL cable_changed_count: got %0d required 1", nch);
        end
    endtask

    task automatic test_glitch();
        int cyc, stray;
        bit ok, mch;
        do_reset();
        plug[4] = 6'b000100;
        for (int f = 1; f <= 8; f++) begin
            step_frame(cyc, ok, stray, mch);
            checks++;
            if (!ok || bus.src !== model_src_vec() || bus.changed !== mch || stray != 0) begin
                errors++;
                $display("FAIL glitch f=%0d: src=%h ch=%b, required src=%h ch=%b",
                         f, bus.src, bus.changed, model_src_vec(), mch);
            end
            checks++;
            if ((f < 8 && (bus.src !== '0 || bus.changed !== 1'b0)) ||
                (f == 8 && bus.src[4*SW +: SW] !== 3'd3)) begin
                errors++;
                $display("FAIL glitch_expect f=%0d: src=%h ch=%b", f, bus.src, bus.changed);
            end
            if (f == 2) plug[4] = '0;
            if (f == 5) plug[4] = 6'b000100;
        end
    endtask

    task automatic test_conflict();
        int cyc, stray;
        bit ok, mch;
        do_reset();
        plug[0] = 6'b001010;
        for (int f = 1; f <= 7; f++) begin
            step_frame(cyc, ok, stray, mch);
            checks++;
            if (!ok || bus.src !== model_src_vec() || bus.conflict !== model_conf_vec() || bus.changed !== mch) begin
                errors++;
                $display("FAIL conflict f=%0d: src=%h conf=%b ch=%b, required src=%h conf=%b ch=%b",
                         f, bus.src, bus.conflict, bus.changed, model_src_vec(), model_conf_vec(), mch);
            end
            checks++;
            if ((f <= 3 && bus.conflict[0] !== 1'b1) || (f >= 4 && bus.conflict[0] !== 1'b0) ||
                (f >= 3 && f <= 5 && bus.src[0 +: SW] !== 3'd2) || (f >= 6 && bus.src[0 +: SW] !== 3'd4)) begin
                errors++;
                $display("FAIL conflict_expect f=%0d: conf0=%b src0=%0d", f, bus.conflict[0], bus.src[0 +: SW]);
            end
            if (f == 3) plug[0] = 6'b001000;
        end
    endtask

    task automatic test_reset_midframe();
        int cyc, stray, total;
        bit ok, mch;
        do_reset();
        plug[4] = 6'b000100;
        repeat (3) step_frame(cyc, ok, stray, mch);
        checks++;
        if (bus.src[4*SW +: SW] !== 3'd3) begin
            errors++;
            $display("FAIL midrst_precommit: got %0d required 3", bus.src[4*SW +: SW]);
        end
        repeat (59) @(posedge clk);
        #1;
        checks++;
        if (bus.drive_low !== 6'b001000) begin
            errors++;
            $display("FAIL midrst_position: got %b required 001000", bus.drive_low);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.drive_low !== '0 || bus.src !== '0 || bus.conflict !== '0 ||
            bus.frame_done !== 1'b0 || bus.changed !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: drive=%b src=%h conf=%b fd=%b ch=%b, required all zero",
                     bus.drive_low, bus.src, bus.conflict, bus.frame_done, bus.changed);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.drive_low !== '0) begin
            errors++;
            $display("FAIL midrst_hold: got %b required 000000", bus.drive_low);
        end
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.drive_low !== 6'b000001) begin
            errors++;
            $display("FAIL midrst_restart: got %b required 000001", bus.drive_low);
        end
        total = 1;
        for (int f = 1; f <= 3; f++) begin
            step_frame(cyc, ok, stray, mch);
            total += cyc;
            checks++;
            if (!ok || bus.src !== model_src_vec() || bus.changed !== mch) begin
                errors++;
                $display("FAIL midrst f=%0d: src=%h ch=%b, required src=%h ch=%b",
                         f, bus.src, bus.changed, model_src_vec(), mch);
            end
        end
        checks++;
        if (total != 309 || bus.src[4*SW +: SW] !== 3'd3) begin
            errors++;
            $display("FAIL midrst_recommit: cycle=%0d src4=%0d, required 309 and 3", total, bus.src[4*SW +: SW]);
        end
    endtask

    task automatic test_random();
        int cyc, stray, nf, r, a, b;
        bit ok, mch;
        do_reset();
        for (int e = 0; e < 14; e++) begin
            for (int k = 0; k < NK; k++) begin
                plug[k] = '0;
                stuck[k] = 1'b0;
                r = $urandom_range(0, 11);
                a = $urandom_range(0, NS - 1);
                b = $urandom_range(0, NS - 1);
                if (r >= 4 && r < 9) plug[k][a] = 1'b1;
                else if (r >= 9 && r < 11) begin plug[k][a] = 1'b1; plug[k][b] = 1'b1; end
                else if (r == 11) stuck[k] = 1'b1;
            end
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                step_frame(cyc, ok, stray, mch);
                checks++;
                if (!ok || cyc != 103 || stray != 0 || bus.src !== model_src_vec() ||
                    bus.conflict !== model_conf_vec() || bus.changed !== mch) begin
                    errors++;
                    $display("FAIL random e=%0d f=%0d: cyc=%0d src=%h conf=%b ch=%b, required 103 src=%h conf=%b ch=%b",
                             e, f, cyc, bus.src, bus.conflict, bus.changed, model_src_vec(), model_conf_vec(), mch);
                end
            end
        end
    endtask

    task automatic test_small_config();
        int cyc;
        plug_s[7] = 3'b001;
        rst_s = 1'b1;
        @(negedge clk); rst_s = 1'b0;
        for (int f = 1; f <= 2; f++) begin
            cyc = 0;
            do begin
                @(posedge clk); #1;
                cyc++;
            end while (!bus_s.frame_done && cyc < 100);
            checks++;
            if (cyc != 16 || bus_s.src !== 16'h4000 || bus_s.conflict !== 8'h00 ||
                bus_s.changed !== (f == 1)) begin
                errors++;
                $display("FAIL small f=%0d: cyc=%0d src=%h conf=%b ch=%b, required 16 4000 0 %b",
                         f, cyc, bus_s.src, bus_s.conflict, bus_s.changed, (f == 1));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_walk();
        test_cable();
        test_glitch();
        test_conflict();
        test_reset_midframe();
        test_random();
        test_small_config();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/patch_matrix_scanner.md
# patch_matrix_scanner

Parametrised patch-cable detector for the synth front panel. It generalises the fixed six-jack patch detection to NUM_SRC open-drain source jacks and NUM_SINK pulled-up sink jacks. It drives one source low at a time, samples every sink after a settle period, and builds a connectivity matrix. Per-sink routing codes are published only after they have been stable for STABLE_SCANS frames. It sits between the pad tristates at top level and the effect-chain routing muxes.

## Interface
- NUM_SRC, 6: number of source jacks (driven, open-drain).
- NUM_SINK, 6: number of sink jacks (sensed, external pull-up).
- SETTLE_CYCLES, 16: cycles each source is held low before sampling; must be ≥ 3.
- STABLE_SCANS, 3: identical consecutive frames required before a route commits; must be ≥ 1.
- SRC_W (derived, not overridable): $clog2(NUM_SRC+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- sense  in  NUM_SINK  raw sink pin levels, asynchronous; 0 means pulled low.
- drive_low  out  NUM_SRC  1 means the pad pulls that source low; 0 means released (Z).
- src  out  NUM_SINK*SRC_W  per-sink committed source code; slice k is bits [k*SRC_W +: SRC_W]; 0 means unpatched, i+1 means source i.
- conflict  out  NUM_SINK  per-sink flag: more than one source read low in the last frame.
- frame_done  out  1  one-cycle pulse at the end of each frame's COMMIT.
- changed  out  1  one-cycle pulse, coincident with frame_done, when any src slice changed.

## Operation
- Synchronise sense through a 2-FF synchroniser; all sampling uses the synchronised value.
- Row index d runs 0..NUM_SRC-1. Settle counter cnt runs 0..SETTLE_CYCLES-1.
- State DRIVE: drive_low = onehot(d). On cnt == SETTLE_CYCLES-1, latch row[d] = ~sense_sync, then go to RELEASE.
- State RELEASE: lasts 1 cycle with drive_low = 0, so the line can recover. Then d increments; if d was NUM_SRC-1, go to COMMIT.
- State COMMIT: lasts 1 cycle with drive_low = 0. Steps:
  - For each sink k, cand[k] = 1 + the lowest d with row[d][k] = 1, or 0 if there is none.
  - conflict[k] = (popcount over d of row[d][k]) > 1. This is registered every frame with no debounce.
  - Debounce: if cand[k] == prev[k], then stab[k] = min(stab[k]+1, STABLE_SCANS); otherwise stab[k] = 1 and prev[k] = cand[k].
  - If the new stab[k] == STABLE_SCANS and cand[k] != src[k], then src[k] <= cand[k].
  - Pulse frame_done. Pulse changed if any src slice updated.
  - Then go to DRIVE with d = 0 and cnt = 0.
- A sink stuck low reads low in every row. It gets cand = 1 and conflict = 1 (when NUM_SRC > 1).
- Reset, asynchronous, takes effect immediately, including mid-frame. Outputs: drive_low = 0, src = 0, conflict = 0, frame_done = 0, changed = 0. Internal: prev = 0, stab = 0, row = 0, synchroniser = 1s, state DRIVE with d = 0 and cnt = 0. A partial frame is discarded.

## Timing
- Frame length: NUM_SRC*(SETTLE_CYCLES+1)+1 cycles. With defaults, 103 cycles.
- The first rising edge after rst deasserts is DRIVE cycle 0 of row 0, with drive_low = 000001.
- Sample point: the last DRIVE cycle of each row. This leaves SETTLE_CYCLES-2 cycles of analog settle beyond the synchroniser.
- src, conflict, frame_done and changed update on the COMMIT edge. Commit latency after a stable patch change is between STABLE_SCANS and STABLE_SCANS+1 frames.
- drive_low is never multi-hot. At least one all-released cycle separates adjacent rows.

## Test plan
- Defaults, sense all 1:
  - drive_low walks 000001 → 100000.
  - Each source is held 16 cycles, separated by 1 released cycle.
  - frame_done fires every 103 cycles.
  - src = 0, conflict = 0, changed never pulses.
- Cable source 2 → sink 4, modelled as sense[4] = ~drive_low[2], present from reset:
  - src slice 4 = 3 at the COMMIT of frame 3 (cycle 309).
  - changed pulses once. All other slices stay 0.
- Glitch: cable present for frames 1–2 only, then removed:
  - src stays 0. changed never pulses.
  - Re-plug for 3 frames: src[4] = 3 commits.
- Conflict: sources 1 and 3 both tied to sink 0:
  - conflict[0] = 1 from frame 1.
  - src[0] = 2 after 3 frames.
  - Unplug source 1: conflict[0] clears next frame; src[0] becomes 4 three frames later.
- Reset mid-frame (row 3, cnt 7) with src[4] = 3 committed:
  - Outputs clear in the same cycle. drive_low = 0 during reset.
  - Restart at row 0. src[4] = 3 re-commits after 3 full frames.
- NUM_SRC=3, NUM_SINK=8, STABLE_SCANS=1, SETTLE_CYCLES=4:
  - Frame = 16 cycles, SRC_W = 2.
  - Cable source 0 → sink 7 gives src[7] = 1 at the first COMMIT (cycle 16).
